comp_serial: RTL

- Multi-cycle magnitude comparator for WIDTH-bit operands.
- Feeds the existing 2-bit cascade slice comp_2 one bit-pair per cycle, MSB pair first.
- Registers the running EQ/GT cascade between cycles.
- Serves the branch/compare path where one comparator slice is shared rather than building a wide combinational chain; produces EQ/GT/LT with a start/done handshake.

---
 rtl/comp_serial_pkg.sv | 15 +
 rtl/comp_serial_comp_2.sv | 21 ++
 rtl/comp_serial.sv | 125 ++++++++++++
 3 files changed

// File: rtl/comp_serial_pkg.sv
// comp_serial_pkg: types and helpers shared by the serial magnitude comparator.
//   state_t   : controller states (IDLE / RUN)
//   idx_width : bit width of the pair index for N bit-pairs (minimum 1)
package comp_serial_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/comp_serial_comp_2.sv
// comp_2: 2-bit magnitude-compare cascade slice.
//   A, B : operand bit-pair for this slice
//   EQ1  : more-significant pairs all equal so far
//   GT1  : A already decided greater by more-significant pairs
//   EQ0  : equality carried out to the next (less significant) slice
//   GT0  : greater-than carried out to the next slice
// Once a more-significant pair has decided the result, EQ1=0 masks this pair,
// so the decision is held through the rest of the cascade.
module comp_2 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       EQ1,
  input  logic       GT1,
  output logic       EQ0,
  output logic       GT0
);

  assign EQ0 = EQ1 & (A == B);
  assign GT0 = GT1 | (EQ1 & (A > B));

endmodule

// File: rtl/comp_serial.sv
// comp_serial: multi-cycle WIDTH-bit magnitude comparator built around a
// single shared comp_2 slice, fed one bit-pair per cycle, MSB pair first.
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   start : compare request, sampled only while busy=0
//   A, B  : operands, captured on an accepted start
//   busy  : compare in progress
//   done  : one-cycle pulse when EQ/GT/LT update
//   EQ/GT/LT : result of the last completed compare, held until the next done
// Latency is fixed at WIDTH/2 cycles from the accepting edge.
module comp_serial
  import comp_serial_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned IDXW = idx_width(N);

  // Inverting the sign bit maps two's-complement order onto unsigned order,
  // so the same unsigned cascade serves the signed compare.
  localparam logic [WIDTH-1:0] SIGN_FLIP =
    SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q, a_n, b_n;
  logic [IDXW-1:0]  idx, idx_n;
  logic             eq_acc, gt_acc, eq_acc_n, gt_acc_n;
  logic             done_n, eq_n, gt_n, lt_n;
  logic [1:0]       a_pair, b_pair;
  logic             eq0, gt0;

  assign a_pair = a_q[{idx, 1'b0} +: 2];
  assign b_pair = b_q[{idx, 1'b0} +: 2];

  comp_2 u_comp_2 (
    .A   (a_pair),
    .B   (b_pair),
    .EQ1 (eq_acc),
    .GT1 (gt_acc),
    .EQ0 (eq0),
    .GT0 (gt0)
  );

  assign busy = (state == RUN);

  always_comb begin
    state_n  = state;
    a_n      = a_q;
    b_n      = b_q;
    idx_n    = idx;
    eq_acc_n = eq_acc;
    gt_acc_n = gt_acc;
    done_n   = 1'b0;
    eq_n     = EQ;
    gt_n     = GT;
    lt_n     = LT;

    case (state)
      IDLE: begin
        if (start) begin
          a_n      = A ^ SIGN_FLIP;
          b_n      = B ^ SIGN_FLIP;
          eq_acc_n = 1'b1;
          gt_acc_n = 1'b0;
          idx_n    = IDXW'(N - 1);
          state_n  = RUN;
        end
      end
      RUN: begin
        eq_acc_n = eq0;
        gt_acc_n = gt0;
        if (idx == '0) begin
          eq_n    = eq0;
          gt_n    = gt0;
          lt_n    = ~eq0 & ~gt0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          idx_n = idx - IDXW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      eq_acc <= 1'b1;
      gt_acc <= 1'b0;
      done   <= 1'b0;
      EQ     <= 1'b0;
      GT     <= 1'b0;
      LT     <= 1'b0;
    end else begin
      state  <= state_n;
      a_q    <= a_n;
      b_q    <= b_n;
      idx    <= idx_n;
      eq_acc <= eq_acc_n;
      gt_acc <= gt_acc_n;
      done   <= done_n;
      EQ     <= eq_n;
      GT     <= gt_n;
      LT     <= lt_n;
    end
  end

endmodule
